// File: rtl/stq_pkg.sv
// Store-queue shared types: length encodings and the buffered entry record,
// also used by the data memory.
package stq_pkg;

    // Widest address an entry can hold; store_queue requires ADDR_W <= this.
    localparam int STQ_ADDR_MAX = 64;

    typedef enum logic [1:0] {
        LEN_BYTE = 2'd0,
        LEN_HALF = 2'd1,
        LEN_TRI  = 2'd2,
        LEN_WORD = 2'd3
    } stq_len_e;

    typedef struct packed {
        logic [STQ_ADDR_MAX-1:0] addr;
        logic [31:0]             data;
        stq_len_e                len;
        logic [31:0]             pc;
    } stq_entry_t;

    // A store must not cross its word: offset + (bytes - 1) stays within lane 3.
    function automatic logic stq_legal(input logic [1:0] off, input logic [1:0] len);
        return ({1'b0, off} + {1'b0, len}) <= 3'd3;
    endfunction

endpackage

// File: rtl/stq_fifo.sv
// Store-queue storage: circular entry array with head/tail/count pointers.
// Exposes every slot plus a per-slot valid mask for the load-match logic.
module stq_fifo
    import stq_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  stq_entry_t              push_ent,
    input  logic                    pop,
    output stq_entry_t              head_ent,
    output stq_entry_t [DEPTH-1:0]  ents,
    output logic [DEPTH-1:0]        vld,
    output logic [PW-1:0]           head,
    output logic [CW-1:0]           count
);

    logic [PW-1:0]          tail;
    stq_entry_t [DEPTH-1:0] mem;

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[tail] <= push_ent;
    end

    assign ents     = mem;
    assign head_ent = mem[head];

    // A slot is live when its distance from head is below the occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_vld
        logic [PW-1:0] age;
        assign age    = PW'(i) - head;
        assign vld[i] = {1'b0, age} < count;
    end

endmodule

// File: rtl/store_queue.sv
// In-order store queue between MEM stage and data memory, with load hazard
// detection. Define STQ_FWD_EN to forward whole-word stores to matching loads.
module store_queue
    import stq_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int ADDR_W = 32,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic [1:0]        st_len,
    input  logic [31:0]       st_pc,
    output logic              st_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    output logic [1:0]        mem_wlen,
    output logic [31:0]       mem_pc,
    input  logic              mem_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_stall,
    output logic              ld_fwd_valid,
    output logic [31:0]       ld_fwd_data,
    output logic [CW-1:0]     count
);

    localparam int PW = $clog2(DEPTH);

    stq_entry_t             push_ent;
    stq_entry_t             head_ent;
    stq_entry_t [DEPTH-1:0] ents;
    logic [DEPTH-1:0]       vld;
    logic [DEPTH-1:0]       hit;
    logic [PW-1:0]          head;
    logic                   legal;
    logic                   accept;
    logic                   pop;
    logic                   any_hit;

    assign legal    = stq_legal(st_addr[1:0], st_len);
    // Ready depends only on occupancy, so a full queue refuses even while draining.
    assign st_ready = count < CW'(DEPTH);
    assign accept   = st_valid && st_ready && legal;
    assign mem_we   = count != '0;
    assign pop      = mem_we && mem_ready;

    assign push_ent = '{addr: STQ_ADDR_MAX'(st_addr), data: st_data,
                        len: stq_len_e'(st_len), pc: st_pc};

    stq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (accept),
        .push_ent (push_ent),
        .pop      (pop),
        .head_ent (head_ent),
        .ents     (ents),
        .vld      (vld),
        .head     (head),
        .count    (count)
    );

    assign mem_addr = head_ent.addr[ADDR_W-1:0];
    assign mem_wd   = head_ent.data;
    assign mem_wlen = head_ent.len;
    assign mem_pc   = head_ent.pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            st_err <= 1'b0;
        else
            st_err <= st_valid && !legal;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_hit
        assign hit[i] = vld[i] && (ents[i].addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]);
    end

    assign any_hit = ld_valid && (|hit);

`ifdef STQ_FWD_EN
    logic [PW-1:0] yidx;
    logic [PW-1:0] slot;
    logic          fwd_ok;

    // Walk oldest to youngest; the last matching slot is the youngest writer.
    always_comb begin
        yidx = head;
        slot = head;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head + PW'(k);
            if (hit[slot])
                yidx = slot;
        end
    end

    assign fwd_ok       = (ents[yidx].len == LEN_WORD) && (ents[yidx].addr[1:0] == 2'b00);
    assign ld_fwd_valid = any_hit && fwd_ok;
    assign ld_fwd_data  = ld_fwd_valid ? ents[yidx].data : 32'h0;
    assign ld_stall     = any_hit && !fwd_ok;
`else
    assign ld_fwd_valid = 1'b0;
    assign ld_fwd_data  = 32'h0;
    assign ld_stall     = any_hit;
`endif

    // Entry fields that only some configurations observe.
    logic unused_bits;
    assign unused_bits = ^{ld_addr[1:0], ents, head_ent, head};

endmodule

// File: tb/tb_store_queue.sv
// Directed and randomized bench for store_queue against a queue-based model.
module tb_store_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          st_valid;
    logic          st_ready;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_data;
    logic [1:0]    st_len;
    logic [31:0]   st_pc;
    logic          st_err;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wd;
    logic [1:0]    mem_wlen;
    logic [31:0]   mem_pc;
    logic          mem_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_stall;
    logic          ld_fwd_valid;
    logic [31:0]   ld_fwd_data;
    logic [2:0]    count;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  len;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] drained[$];
    bit          err_exp;
    int          checks = 0;
    int          errors = 0;

    store_queue #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_len(st_len), .st_pc(st_pc), .st_err(st_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_wlen(mem_wlen), .mem_pc(mem_pc), .mem_ready(mem_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall),
        .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Youngest queued store to the same word decides stall vs forward.
    function automatic void model_ld(output bit stall, output bit fv, output logic [31:0] fd);
        stall = 0;
        fv    = 0;
        fd    = '0;
        if (!ld_valid)
            return;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].addr[31:2] == ld_addr[31:2]) begin
`ifdef STQ_FWD_EN
                if (q[i].len == 2'd3 && q[i].addr[1:0] == 2'd0) begin
                    fv = 1;
                    fd = q[i].data;
                end else begin
                    stall = 1;
                end
`else
                stall = 1;
`endif
                return;
            end
        end
    endfunction

    task automatic check_all(input string tag);
        bit          s;
        bit          fv;
        logic [31:0] fd;
        #1;
        model_ld(s, fv, fd);
        chk({tag, ".count"}, 64'(count), 64'(q.size()));
        chk({tag, ".st_ready"}, 64'(st_ready), 64'(q.size() < DEPTH));
        chk({tag, ".mem_we"}, 64'(mem_we), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk({tag, ".mem_addr"}, 64'(mem_addr), 64'(q[0].addr));
            chk({tag, ".mem_wd"}, 64'(mem_wd), 64'(q[0].data));
            chk({tag, ".mem_wlen"}, 64'(mem_wlen), 64'(q[0].len));
            chk({tag, ".mem_pc"}, 64'(mem_pc), 64'(q[0].pc));
        end
        chk({tag, ".st_err"}, 64'(st_err), 64'(err_exp));
        chk({tag, ".ld_stall"}, 64'(ld_stall), 64'(s));
        chk({tag, ".ld_fwd_valid"}, 64'(ld_fwd_valid), 64'(fv));
        if (fv)
            chk({tag, ".ld_fwd_data"}, 64'(ld_fwd_data), 64'(fd));
`ifndef STQ_FWD_EN
        chk({tag, ".ld_fwd_data0"}, 64'(ld_fwd_data), 64'h0);
`endif
    endtask

    // One clock edge; the model applies the spec's accept/dequeue rules.
    task automatic tick();
        bit ill;
        bit acc;
        bit pop;
        ill = st_valid && (({1'b0, st_addr[1:0]} + {1'b0, st_len}) > 3'd3);
        acc = st_valid && !ill && (q.size() < DEPTH);
        pop = (q.size() != 0) && mem_ready;
        @(posedge clk);
        #1;
        if (pop) begin
            drained.push_back(q[0].data);
            void'(q.pop_front());
        end
        if (acc)
            q.push_back('{st_addr, st_data, st_len, st_pc});
        err_exp = ill;
    endtask

    task automatic drive_st(input bit v, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] l, input logic [31:0] pc);
        st_valid = v;
        st_addr  = a;
        st_data  = d;
        st_len   = l;
        st_pc    = pc;
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b0;
        ld_valid  = 1'b0;
        ld_addr   = '0;
        drive_st(0, 0, 0, 0, 0);
        err_exp   = 0;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Single word store, memory always ready
        mem_ready = 1'b1;
        drive_st(1, 32'h10, 32'hDEADBEEF, 2'd3, 32'h400);
        check_all("t1.pre");
        chk("t1.nobypass", 64'(mem_we), 64'h0);
        tick();
        drive_st(0, 0, 0, 0, 0);
        check_all("t1.acc");
        chk("t1.we", 64'(mem_we), 64'h1);
        chk("t1.addr", 64'(mem_addr), 64'h10);
        chk("t1.wd", 64'(mem_wd), 64'hDEADBEEF);
        chk("t1.cnt1", 64'(count), 64'h1);
        tick();
        check_all("t1.drain");
        chk("t1.cnt0", 64'(count), 64'h0);

        // Fill past capacity with memory stalled, then drain
        mem_ready = 1'b0;
        drained.delete();
        for (int i = 1; i <= 4; i++) begin
            drive_st(1, 32'h100 + 32'(4 * i), 32'(i), 2'd3, 32'h500 + 32'(i));
            check_all("t2.fill");
            tick();
        end
        drive_st(1, 32'h114, 32'd5, 2'd3, 32'h505);
        check_all("t2.full");
        chk("t2.ready0", 64'(st_ready), 64'h0);
        tick();
        check_all("t2.held");
        chk("t2.cnt4", 64'(count), 64'h4);
        mem_ready = 1'b1;
        check_all("t2.fullpop");
        tick();
        check_all("t2.blocked");
        chk("t2.cnt3a", 64'(count), 64'h3);
        tick();
        check_all("t2.both");
        chk("t2.cnt3b", 64'(count), 64'h3);
        drive_st(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("t2.drain");
        end
        chk("t2.ndrained", 64'(drained.size()), 64'd5);
        for (int k = 0; k < 5 && k < drained.size(); k++)
            chk("t2.order", 64'(drained[k]), 64'(k + 1));

        // Misaligned half-word at offset 3
        mem_ready = 1'b0;
        drive_st(1, 32'h30, 32'hCAFEF00D, 2'd3, 32'h600);
        tick();
        drive_st(1, 32'h13, 32'h0000BEEF, 2'd1, 32'h604);
        tick();
        drive_st(0, 0, 0, 0, 0);
        check_all("t3.err");
        chk("t3.pulse", 64'(st_err), 64'h1);
        chk("t3.cnt", 64'(count), 64'h1);
        tick();
        check_all("t3.clr");
        chk("t3.pulse0", 64'(st_err), 64'h0);

        // Load hazards
        drive_st(1, 32'h20, 32'h000000AA, 2'd0, 32'h700);
        tick();
        drive_st(0, 0, 0, 0, 0);
        ld_valid = 1'b1;
        ld_addr  = 32'h22;
        check_all("t4.byte");
        chk("t4.stall", 64'(ld_stall), 64'h1);
        ld_addr = 32'h28;
        check_all("t4.nomatch");
        chk("t4.nostall", 64'(ld_stall), 64'h0);
        drive_st(1, 32'h24, 32'h12345678, 2'd3, 32'h704);
        tick();
        drive_st(0, 0, 0, 0, 0);
        ld_addr = 32'h24;
        check_all("t4.word");
`ifdef STQ_FWD_EN
        chk("t4.fwdv", 64'(ld_fwd_valid), 64'h1);
        chk("t4.fwdd", 64'(ld_fwd_data), 64'h12345678);
        chk("t4.fwdstall", 64'(ld_stall), 64'h0);
`else
        chk("t4.wstall", 64'(ld_stall), 64'h1);
`endif
        ld_valid = 1'b0;
        check_all("t4.idle");
        chk("t4.idlestall", 64'(ld_stall), 64'h0);
        drive_st(1, 32'h25, 32'h0000BB00, 2'd0, 32'h708);
        tick();
        drive_st(0, 0, 0, 0, 0);
        ld_valid = 1'b1;
        check_all("t4.younger");
        chk("t4.ystall", 64'(ld_stall), 64'h1);
        ld_valid = 1'b0;

        // Reset mid-operation with three pending
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check_all("t5.pending");
        chk("t5.cnt3", 64'(count), 64'h3);
        #2;
        reset = 1'b1;
        q.delete();
        err_exp = 0;
        #1;
        chk("t5.we0", 64'(mem_we), 64'h0);
        chk("t5.cnt0", 64'(count), 64'h0);
        chk("t5.ready1", 64'(st_ready), 64'h1);
        mem_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_all("t5.quiet");
        end

        // Randomized traffic over a small address window
        for (int n = 0; n < 800; n++) begin
            mem_ready = (n < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            drive_st(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom,
                     2'($urandom_range(0, 3)), $urandom);
            ld_valid = 1'($urandom_range(0, 1));
            ld_addr  = 32'($urandom_range(0, 63));
            check_all("rnd");
            tick();
        end
        drive_st(0, 0, 0, 0, 0);
        ld_valid = 1'b0;
        check_all("end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_queue.md
STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of two, 2..16).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset; clock clk.
REQ-005 SHALL have port st_valid  in  1  store request from MEM stage.
REQ-006 SHALL have port st_ready  out  1  queue can accept a store.
REQ-007 SHALL have port st_addr  in  ADDR_W  byte address.
REQ-008 SHALL have port st_data  in  32  store data, already lane-aligned.
REQ-009 SHALL have port st_len  in  2  bytes minus one (0=byte, 1=half, 2=3-byte, 3=word).
REQ-010 SHALL have port st_pc  in  32  PC of the store, carried for the write trace.
REQ-011 SHALL have port st_err  out  1  one-cycle pulse on a misaligned request.
REQ-012 SHALL have ports mem_we/mem_addr/mem_wd/mem_wlen/mem_pc  out  1/ADDR_W/32/2/32  head entry driven to the data memory.
REQ-013 SHALL have port mem_ready  in  1  data memory accepts the head this cycle.
REQ-014 SHALL have ports ld_valid/ld_addr  in  1/ADDR_W  load lookup.
REQ-015 SHALL have port ld_stall  out  1  load must wait.
REQ-016 SHALL have ports ld_fwd_valid/ld_fwd_data  out  1/32  forwarded load word.
REQ-017 SHALL have port count  out  $clog2(DEPTH)+1  occupancy.

Function
REQ-018 SHALL be an in-order FIFO; a store is accepted on a clock edge where st_valid && st_ready && legal.
REQ-019 SHALL define legal as st_addr[1:0] + st_len <= 3; an illegal request is not enqueued and st_err is asserted on the next cycle for exactly one cycle.
REQ-020 SHALL drive st_ready = (count < DEPTH); a full queue never accepts, even when draining that cycle.
REQ-021 SHALL drive mem_we = (count != 0), with mem_* fields taken from the head entry combinationally.
REQ-022 SHALL dequeue the head on a clock edge where mem_we && mem_ready.
REQ-023 SHALL keep count unchanged on a simultaneous accept and dequeue; the accepted entry becomes tail.
REQ-024 SHALL present a newly accepted store on mem_* no earlier than the cycle after acceptance (no bypass when empty).
REQ-025 SHALL wrap head/tail pointers modulo DEPTH.
REQ-026 SHALL assert ld_stall combinationally when ld_valid and any valid entry has addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2], unless forwarding applies (REQ-031).
REQ-027 SHALL deassert ld_stall, ld_fwd_valid whenever ld_valid is low.
REQ-028 SHALL hold mem_* and entry contents stable while mem_we && !mem_ready.

Reset
REQ-029 SHALL, on reset, clear head, tail and count to 0, drive mem_we, st_err, ld_stall and ld_fwd_valid to 0, and st_ready to 1, all immediately.
REQ-030 SHALL discard any buffered stores when reset asserts mid-operation; none reach memory.

Configuration
REQ-031 SHALL, with macro STQ_FWD_EN defined, forward when the youngest matching entry is a word store (len 3, offset 0): ld_fwd_valid=1, ld_fwd_data=its data, ld_stall=0; any other match stalls.
REQ-032 SHALL, without STQ_FWD_EN, tie ld_fwd_valid and ld_fwd_data to 0 and stall on every match.

Structure
REQ-033 SHALL place length encodings (LEN_BYTE, LEN_HALF, LEN_TRI, LEN_WORD) and the entry record (addr, data, len, pc) typedef in shared package stq_pkg, also used by the data memory.
REQ-034 SHALL implement storage and pointers in one sub-module stq_fifo; match/forward logic stays in store_queue.

Verification
REQ-035 SHALL cover: reset, one word store 0x10/0xDEADBEEF, mem_ready=1 -> mem_we high next cycle with those values, count 1->0 after one edge.
REQ-036 SHALL cover: 5 stores with mem_ready=0 (DEPTH 4) -> st_ready=0 after 4th, 5th held; mem_ready=1 -> drain order 1..5 exactly.
REQ-037 SHALL cover: st_addr=0x13, st_len=1 -> st_err one-cycle pulse, count unchanged.
REQ-038 SHALL cover: queued byte store 0x20, ld_addr=0x22 -> ld_stall=1; queued word store 0x24/0x12345678, ld_addr=0x24 -> ld_fwd_data=0x12345678 with STQ_FWD_EN, ld_stall=1 without.
REQ-039 SHALL cover: full queue with accept and dequeue same edge blocked (st_ready=0), then count 3 with both -> count stays 3; reset asserted with 3 pending -> mem_we=0 immediately, no writes after.
